// File: rtl/sample_ram_scheduler.sv
// Purpose: shares data-RAM port B between the ADC sample writer (4-entry write FIFO, per-channel
//          circular buffers) and the VGA reader; VGA reads win unless the FIFO head waited MAX_WAIT
//          cycles or the FIFO is full. Optional SCHED_STATS_EN macro adds drop/stall counters.
// Latency: RAM command issued combinationally in the arbitration cycle; vga_rd_valid one cycle after gnt.
// Backpressure: adc_ready low while the FIFO holds FIFO_DEPTH entries; samples offered then are dropped.

// Small generic FIFO: registered pointers/count, head visible combinationally, push ignored when full.
module sample_ram_scheduler_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push_vld && (count != CW'(DEPTH));
  assign do_pop   = pop_rdy && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module sample_ram_scheduler #(
  parameter logic [11:0] EMG_BASE   = 12'hC7F,
  parameter logic [11:0] ECG_BASE   = 12'h801,
  parameter int          BUF_DEPTH  = 640,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_WAIT   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adc_valid,
  input  logic        adc_ch,
  input  logic [31:0] adc_data,
  output logic        adc_ready,
  input  logic        vga_rd_req,
  input  logic [11:0] vga_rd_addr,
  output logic        vga_rd_gnt,
  output logic        vga_rd_valid,
  output logic [31:0] vga_rd_data,
  output logic [9:0]  emg_wr_idx,
  output logic [9:0]  ecg_wr_idx,
  output logic        ram_we_b,
  output logic [11:0] ram_addr_b,
  output logic [31:0] ram_din_b,
  input  logic [31:0] ram_dout_b
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0] drop_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic        ch;
    logic [31:0] dat;
  } sample_t;

  sample_t       head;
  sample_t       push_smp;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_vld;
  logic [WW-1:0] wait_cnt;
  logic          do_write;
  logic          do_read;
  logic [11:0]   head_base;
  logic [9:0]    head_idx;

  assign push_smp   = '{ch: adc_ch, dat: adc_data};
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  // Readiness comes from the registered count only, so a same-cycle pop never opens a slot.
  assign adc_ready  = !fifo_full;
  assign push_vld   = adc_valid && adc_ready;

  sample_ram_scheduler_fifo #(
    .W     ($bits(sample_t)),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_wr_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_smp),
    .pop_rdy  (do_write),
    .head_dat (head),
    .count    (fifo_count)
  );

  // Arbitration: VGA reads win unless the head has waited long enough or the FIFO is full.
  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    if (!fifo_empty && (!vga_rd_req || (wait_cnt >= WW'(MAX_WAIT)) || fifo_full)) begin
      do_write = 1'b1;
    end else if (vga_rd_req) begin
      do_read = 1'b1;
    end
  end

  // Write address for the FIFO head: channel base plus that channel's next index, 12-bit modulo.
  always_comb begin
    head_base = EMG_BASE;
    head_idx  = emg_wr_idx;
    if (head.ch) begin
      head_base = ECG_BASE;
      head_idx  = ecg_wr_idx;
    end
  end

  // Port-B drive: the address follows the VGA request whenever no write is issued.
  always_comb begin
    ram_we_b   = do_write;
    ram_addr_b = vga_rd_addr;
    ram_din_b  = head.dat;
    vga_rd_gnt = do_read;
    if (do_write) ram_addr_b = head_base + {2'b00, head_idx};
  end

  assign vga_rd_data = ram_dout_b;

  // Read data returns one cycle after the grant, matching the synchronous RAM latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vga_rd_valid <= 1'b0;
    else       vga_rd_valid <= do_read;
  end

  // Per-channel circular indices advance only when the sample actually reaches the RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      emg_wr_idx <= '0;
      ecg_wr_idx <= '0;
    end else if (do_write) begin
      if (head.ch) begin
        ecg_wr_idx <= (ecg_wr_idx == 10'(BUF_DEPTH - 1)) ? '0 : ecg_wr_idx + 1'b1;
      end else begin
        emg_wr_idx <= (emg_wr_idx == 10'(BUF_DEPTH - 1)) ? '0 : emg_wr_idx + 1'b1;
      end
    end
  end

  // Head-blocked age: cleared by a write, saturating count while a queued sample is held off.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (do_write) begin
      wait_cnt <= '0;
    end else if (!fifo_empty && (wait_cnt != WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef SCHED_STATS_EN
  // Saturating counters for samples lost to a full FIFO and VGA requests left waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (adc_valid && !adc_ready && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
      if (vga_rd_req && !do_read && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule
